// File: rtl/mux_n1_pipe_reg_if.sv
// rtl/mux_n1_pipe_reg_if.sv - select/handshake bundle for mux_n1_pipe_reg
interface mux_n1_pipe_reg_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
);
    logic [N*WIDTH-1:0] IN_BUS;
    logic [SELW-1:0]    SEL;
    logic               IN_VALID;
    logic               IN_READY;
    logic               FLUSH;
    logic [WIDTH-1:0]   OUT;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic               SEL_ERR;

    modport master (
        output IN_BUS, SEL, IN_VALID, FLUSH, OUT_READY,
        input  IN_READY, OUT, OUT_VALID, SEL_ERR
    );

    modport slave (
        input  IN_BUS, SEL, IN_VALID, FLUSH, OUT_READY,
        output IN_READY, OUT, OUT_VALID, SEL_ERR
    );
endinterface

// File: rtl/mux_n1_pipe_reg.sv
// rtl/mux_n1_pipe_reg.sv - N:1 select into a main+skid registered output stage (optional SEL_ERR_EN)
module mux_n1_pipe_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    mux_n1_pipe_reg_if.slave  bus
);
    logic [WIDTH-1:0] sel_word;
    logic             accept;
    logic             drain;

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             in_ready_q,   in_ready_d;

    // Out-of-range selects fall through to all-ones.
    always_comb begin
        sel_word = '1;
        for (int k = 0; k < N; k++) begin
            if (bus.SEL == SELW'(k)) begin
                sel_word = bus.IN_BUS[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = bus.IN_VALID & in_ready_q;
    assign drain  = main_valid_q & bus.OUT_READY;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (bus.FLUSH) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (drain) begin
                main_data_d  = skid_data_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = sel_word;
                end
            end
        end else if (!main_valid_q || drain) begin
            main_valid_d = accept;
            if (accept) begin
                main_data_d = sel_word;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = sel_word;
        end
        // Ready is a flop of next-cycle skid emptiness, so OUT_READY never reaches IN_READY.
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.OUT       = main_data_q;
    assign bus.OUT_VALID = main_valid_q;
    assign bus.IN_READY  = in_ready_q;

`ifdef SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    always_comb begin
        sel_err_d = sel_err_q;
        if (accept && !bus.FLUSH && (32'(bus.SEL) >= 32'(N))) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.SEL_ERR = sel_err_q;
`else
    assign bus.SEL_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_mux_n1_pipe_reg.sv
// tb/tb_mux_n1_pipe_reg.sv - bench for mux_n1_pipe_reg (N=4 and N=3 instances, honours SEL_ERR_EN)
module tb_mux_n1_pipe_reg;
`ifdef SEL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_n1_pipe_reg_if #(.WIDTH(32), .N(4)) if4 ();
    mux_n1_pipe_reg_if #(.WIDTH(32), .N(3)) if3 ();

    mux_n1_pipe_reg #(.WIDTH(32), .N(4)) dut4 (.CLK(clk), .RESET_N(rst_n), .bus(if4));
    mux_n1_pipe_reg #(.WIDTH(32), .N(3)) dut3 (.CLK(clk), .RESET_N(rst_n), .bus(if3));

    int n_checks = 0;
    int n_fail   = 0;
    logic rdy_snap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each instance is a 2-deep FIFO; ready means fewer than two words held.
    logic [31:0] q4[$];
    logic [31:0] q3[$];
    logic        err3 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q4.delete();
            q3.delete();
            err3 <= 1'b0;
        end else begin
            if (if4.FLUSH) begin
                q4.delete();
            end else if (if4.OUT_READY && q4.size() != 0) begin
                if (if4.IN_VALID && q4.size() < 2) q4.push_back(if4.IN_BUS[if4.SEL*32 +: 32]);
                void'(q4.pop_front());
            end else if (if4.IN_VALID && q4.size() < 2) begin
                q4.push_back(if4.IN_BUS[if4.SEL*32 +: 32]);
            end

            if (ERR_EN && !if3.FLUSH && if3.IN_VALID && q3.size() < 2 && if3.SEL == 2'd3) err3 <= 1'b1;
            if (if3.FLUSH) begin
                q3.delete();
            end else if (if3.OUT_READY && q3.size() != 0) begin
                if (if3.IN_VALID && q3.size() < 2)
                    q3.push_back((if3.SEL < 2'd3) ? if3.IN_BUS[if3.SEL*32 +: 32] : 32'hFFFF_FFFF);
                void'(q3.pop_front());
            end else if (if3.IN_VALID && q3.size() < 2) begin
                q3.push_back((if3.SEL < 2'd3) ? if3.IN_BUS[if3.SEL*32 +: 32] : 32'hFFFF_FFFF);
            end
        end
    end

    always @(negedge clk) begin
        chk("m4_valid", {31'b0, if4.OUT_VALID}, {31'b0, q4.size() != 0});
        chk("m4_ready", {31'b0, if4.IN_READY},  {31'b0, q4.size() < 2});
        if (q4.size() != 0) chk("m4_out", if4.OUT, q4[0]);
        chk("m3_valid", {31'b0, if3.OUT_VALID}, {31'b0, q3.size() != 0});
        chk("m3_ready", {31'b0, if3.IN_READY},  {31'b0, q3.size() < 2});
        if (q3.size() != 0) chk("m3_out", if3.OUT, q3[0]);
        chk("m3_sel_err", {31'b0, if3.SEL_ERR}, {31'b0, err3});
    end

    initial begin
        if4.IN_BUS = '0; if4.SEL = '0; if4.IN_VALID = 1'b0; if4.FLUSH = 1'b0; if4.OUT_READY = 1'b1;
        if3.IN_BUS = '0; if3.SEL = '0; if3.IN_VALID = 1'b0; if3.FLUSH = 1'b0; if3.OUT_READY = 1'b1;
        repeat (2) tick();
        chk("rst_out",     if4.OUT, 32'h0);
        chk("rst_valid",   {31'b0, if4.OUT_VALID}, 32'd0);
        chk("rst_ready",   {31'b0, if4.IN_READY}, 32'd1);
        chk("rst_sel_err", {31'b0, if3.SEL_ERR}, 32'd0);
        rst_n = 1'b1;

        // In-order select of every channel, one word per cycle
        for (int k = 0; k < 4; k++) if4.IN_BUS[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        if4.IN_VALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if4.SEL = 2'(k);
            tick();
            chk("t1_out",   if4.OUT, 32'h1000_0000 + 32'(k));
            chk("t1_valid", {31'b0, if4.OUT_VALID}, 32'd1);
        end
        if4.IN_VALID = 1'b0;
        tick();
        chk("t1_drained", {31'b0, if4.OUT_VALID}, 32'd0);

        // Back-pressure fills main then skid
        if4.SEL = 2'd0; if4.OUT_READY = 1'b0; if4.IN_VALID = 1'b1;
        if4.IN_BUS[31:0] = 32'hAAAA_0001; tick();
        chk("t2_a_out", if4.OUT, 32'hAAAA_0001);
        chk("t2_a_rdy", {31'b0, if4.IN_READY}, 32'd1);
        if4.IN_BUS[31:0] = 32'hBBBB_0002; tick();
        chk("t2_b_out", if4.OUT, 32'hAAAA_0001);
        chk("t2_b_rdy", {31'b0, if4.IN_READY}, 32'd0);
        if4.IN_BUS[31:0] = 32'hCCCC_0003; tick();
        chk("t2_c_hold", if4.OUT, 32'hAAAA_0001);
        chk("t2_c_rdy",  {31'b0, if4.IN_READY}, 32'd0);
        if4.OUT_READY = 1'b1; tick();
        chk("t2_out_b", if4.OUT, 32'hBBBB_0002);
        chk("t2_rdy_b", {31'b0, if4.IN_READY}, 32'd1);
        tick();
        chk("t2_out_c", if4.OUT, 32'hCCCC_0003);
        if4.IN_VALID = 1'b0; tick();
        chk("t2_drained", {31'b0, if4.OUT_VALID}, 32'd0);

        // Flush with both entries full and a word offered
        if4.OUT_READY = 1'b0; if4.IN_VALID = 1'b1;
        if4.IN_BUS[31:0] = 32'hDDDD_0004; tick();
        if4.IN_BUS[31:0] = 32'hEEEE_0005; tick();
        chk("t4_full_rdy", {31'b0, if4.IN_READY}, 32'd0);
        if4.FLUSH = 1'b1; if4.IN_BUS[31:0] = 32'hFFFF_0006; tick();
        chk("t4_fl_valid", {31'b0, if4.OUT_VALID}, 32'd0);
        chk("t4_fl_rdy",   {31'b0, if4.IN_READY}, 32'd1);
        if4.FLUSH = 1'b0; if4.IN_VALID = 1'b0; if4.OUT_READY = 1'b1; tick();
        chk("t4_after", {31'b0, if4.OUT_VALID}, 32'd0);
        // Flush while ready=1 discards the simultaneously accepted word
        if4.IN_VALID = 1'b1; if4.IN_BUS[31:0] = 32'h1234_0007; tick();
        chk("t4_g_out", if4.OUT, 32'h1234_0007);
        if4.OUT_READY = 1'b0; if4.FLUSH = 1'b1; if4.IN_BUS[31:0] = 32'h1234_0008; tick();
        chk("t4_h_valid", {31'b0, if4.OUT_VALID}, 32'd0);
        if4.FLUSH = 1'b0; if4.IN_VALID = 1'b0; if4.OUT_READY = 1'b1; tick();
        chk("t4_h_gone", {31'b0, if4.OUT_VALID}, 32'd0);

        // Out-of-range select on the N=3 instance
        if3.IN_BUS = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        if3.SEL = 2'd3; tick();
        chk("t3_idle_err", {31'b0, if3.SEL_ERR}, 32'd0);
        if3.IN_VALID = 1'b1; tick();
        chk("t3_ones",  if3.OUT, 32'hFFFF_FFFF);
        chk("t3_err",   {31'b0, if3.SEL_ERR}, {31'b0, ERR_EN});
        if3.IN_VALID = 1'b0; if3.FLUSH = 1'b1; tick();
        chk("t3_err_fl", {31'b0, if3.SEL_ERR}, {31'b0, ERR_EN});
        if3.FLUSH = 1'b0; if3.SEL = 2'd1; if3.IN_VALID = 1'b1; tick();
        chk("t3_ch1", if3.OUT, 32'h3333_0001);
        if3.IN_VALID = 1'b0; tick();

        // Asynchronous reset between edges with words buffered
        if4.OUT_READY = 1'b0; if4.IN_VALID = 1'b1;
        if4.IN_BUS[31:0] = 32'h5555_0001; tick();
        if4.IN_BUS[31:0] = 32'h5555_0002; tick();
        if4.IN_VALID = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_out",   if4.OUT, 32'h0);
        chk("t6_valid", {31'b0, if4.OUT_VALID}, 32'd0);
        chk("t6_ready", {31'b0, if4.IN_READY}, 32'd1);
        chk("t6_err",   {31'b0, if3.SEL_ERR}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Random traffic checked by the reference every cycle
        for (int c = 0; c < 3000; c++) begin
            if4.IN_VALID  = 1'($urandom_range(0, 1));
            if4.OUT_READY = ($urandom_range(0, 3) != 0);
            if4.FLUSH     = ($urandom_range(0, 49) == 0);
            if4.SEL       = 2'($urandom_range(0, 3));
            if4.IN_BUS    = {$urandom, $urandom, $urandom, $urandom};
            if3.IN_VALID  = 1'($urandom_range(0, 1));
            if3.OUT_READY = 1'($urandom_range(0, 1));
            if3.FLUSH     = ($urandom_range(0, 49) == 0);
            if3.SEL       = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if3.IN_BUS    = {$urandom, $urandom, $urandom};
            if (c % 8 == 0) begin
                rdy_snap = if4.IN_READY;
                if4.OUT_READY = ~if4.OUT_READY;
                #1;
                chk("comb_ready", {31'b0, if4.IN_READY}, {31'b0, rdy_snap});
                if4.OUT_READY = ~if4.OUT_READY;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
